mc6502_memory_controller: RTL and testbench
===========================================

Name: mc6502_memory_controller

Overview:
- Bus-side stage of the 6502 core, directly downstream of the execution controller.
- Performs opcode/operand fetches at PC and effective-address generation for all indexed and indirect modes.
- Performs data reads and stores for the decoder.
- Performs the read-modify-write writeback requested by the execution controller (ec2mc_store/ec2mc_data) to the last effective address.
- Drives a single synchronous-read memory port: data is returned one cycle after rd.

Parameters:
- ZP_WRAP, 1: 1 = ZP,X / ZP,Y sums and indirect pointer+1 wrap inside page 0; 0 = carry propagates into page 1.

Ports:
- clk  in  1  clock
- rst_x  in  1  reset
- id2mc_fetch  in  1  read the byte at {rf2mc_pch,rf2mc_pcl}
- id2mc_start  in  1  start an effective-address access
- id2mc_write  in  1  with start: store id2mc_wdata (1) instead of read (0)
- id2mc_mode  in  3  addressing mode: 0 ZP, 1 ZPX, 2 ZPY, 3 ABS, 4 ABSX, 5 ABSY, 6 INDX, 7 INDY
- id2mc_lo  in  8  operand low byte
- id2mc_hi  in  8  operand high byte (ABS modes only)
- id2mc_wdata  in  8  store data
- mc2id_data  out  8  read result, valid only when mc2id_done=1
- mc2id_done  out  1  one-cycle completion pulse, for all request types
- mc2id_busy  out  1  high in every non-IDLE state
- ec2mc_data  in  8  RMW writeback data
- ec2mc_store  in  1  write ec2mc_data to the latched effective address
- rf2mc_pcl, rf2mc_pch, rf2mc_x, rf2mc_y  in  8 each  register values
- mem_adr  out  16  bus address
- mem_dout  out  8  write data
- mem_din  in  8  read data, valid in the cycle after mem_rd
- mem_rd  out  1  read strobe
- mem_we  out  1  write strobe

Behaviour:
- Reset: rst_x is an asynchronous, active-low reset; clk is the clock. On reset: state=IDLE, r_ea=0, r_lo=r_hi=0, r_wdata=0. All outputs are then 0: adr, dout, rd, we, done, busy, data.
- Outputs are decoded from the registered state and registers.
- Request sampling:
  - Requests are sampled only in IDLE; requests in any other state are ignored and are not queued.
  - Priority when several requests are high in the same cycle: ec2mc_store > id2mc_start > id2mc_fetch.
  - On acceptance, the request, the mode and all operand/index inputs are latched.
- State sequence:
  - IDLE: accepting cycle N.
  - PTR_LO: adr=ptr, rd=1.
  - PTR_HI: r_lo<=din, adr=ptr+1, rd=1.
  - PTR_WAIT: r_hi<=din.
  - ACCESS: adr=EA (fetch: PC), rd=1 for reads or we=1 with dout set for writes.
  - RD_WAIT: done=1, data=mem_din.
  - After RD_WAIT, return to IDLE.
- Transitions and latencies:
  - Direct modes (0-5) and fetch: IDLE -> ACCESS.
  - Indirect modes (6-7): IDLE -> PTR_LO -> PTR_HI -> PTR_WAIT -> ACCESS.
  - ACCESS -> RD_WAIT for reads. For writes, done pulses in ACCESS and the next state is IDLE.
  - Read latency: done at N+2 (direct) or N+5 (indirect).
  - Write latency: done at N+1 (direct) or N+4 (indirect).
  - RMW store: IDLE -> ACCESS, using r_ea and ec2mc_data latched at N; done at N+1.
- Effective address:
  - ZP: {00,lo}.
  - ZPX/ZPY: lo+X / lo+Y, 8-bit wrap when ZP_WRAP=1.
  - ABS: {hi,lo}.
  - ABSX/ABSY: {hi,lo}+X / +Y, 16-bit; FFFF+1 wraps to 0000.
  - INDX: ptr=lo+X (8-bit wrap); EA={r_hi,r_lo}.
  - INDY: ptr=lo; EA={r_hi,r_lo}+Y, 16-bit.
  - ptr+1 wraps within page 0 when ZP_WRAP=1; e.g. ptr FF -> 00.
- EA latching: r_ea is updated on every start access (read or write), in the cycle ACCESS is entered. Fetch and store do not modify r_ea.
- Store before any start: writes to address 0000.
- Indirect fetches always assert rd and never we.
- Asynchronous reset mid-operation: aborts the access immediately; no done pulse is produced.

Decomposition:
- MC6502Common.vh gains:
  - addressing-mode constants AM_ZP..AM_INDY;
  - state encodings MC_IDLE, MC_PTR_LO, MC_PTR_HI, MC_PTR_WAIT, MC_ACCESS, MC_RD_WAIT.
- One combinational sub-module, mc6502_address_adder:
  - inputs: base[15:0], index[7:0], zp_wrap;
  - output: 16-bit sum.
  - Used for the EA computation and for ptr+1.

Test Plan:
- Fetch: PC=1234, memory[1234]=A9, fetch at N -> adr=1234 and rd at N+1; done and data=A9 at N+2; busy high N+1..N+2.
- ZPX wrap: lo=F0, X=20, memory[0010]=55, read -> adr=0010; data=55 at N+2. Repeat with ZP_WRAP=0 -> adr=0110.
- INDY page cross: lo=FF, memory[00FF]=F0, memory[0000]=12, Y=20 -> PTR adr 00FF then 0000; ACCESS adr=1310; done at N+5.
- Write then RMW: STA ABSX hi=20, lo=FF, X=01, wdata=77 -> we at adr=2100, done at N+1. Then ec2mc_store with data=78 -> we at adr=2100, dout=78, done at N+1.
- Priority and busy: ec2mc_store, start and fetch high together in IDLE -> only the store executes. A fetch asserted while busy is dropped (no second done).
- Reset mid-INDX: rst_x low during PTR_HI -> all outputs 0 immediately; after release, state is IDLE and the next fetch completes normally.

Source files
------------

// File: rtl/mc6502_memory_controller_pkg.sv
// Shared types for the 6502 memory controller: addressing modes, controller
// states and the kind of request currently being served.
package mc6502_memory_controller_pkg;

  typedef enum logic [2:0] {
    AM_ZP   = 3'd0,
    AM_ZPX  = 3'd1,
    AM_ZPY  = 3'd2,
    AM_ABS  = 3'd3,
    AM_ABSX = 3'd4,
    AM_ABSY = 3'd5,
    AM_INDX = 3'd6,
    AM_INDY = 3'd7
  } am_e;

  typedef enum logic [2:0] {
    MC_IDLE,
    MC_PTR_LO,
    MC_PTR_HI,
    MC_PTR_WAIT,
    MC_ACCESS,
    MC_RD_WAIT
  } mc_state_e;

  typedef enum logic [1:0] {
    REQ_FETCH,
    REQ_READ,
    REQ_WRITE,
    REQ_STORE
  } req_e;

  function automatic logic is_write_req(req_e k);
    return (k == REQ_WRITE) || (k == REQ_STORE);
  endfunction

endpackage

// File: rtl/mc6502_memory_controller_adder.sv
// Address adder: 16-bit base plus 8-bit index, optionally wrapping the sum
// inside page 0 (used for zero-page indexing and pointer+1).
module mc6502_address_adder (
  input  logic [15:0] base,
  input  logic [7:0]  index,
  input  logic        zp_wrap,
  output logic [15:0] sum
);

  logic [7:0] lo_sum;

  always_comb begin
    lo_sum = base[7:0] + index;
    if (zp_wrap) begin
      sum = {8'h00, lo_sum};
    end else begin
      sum = base + {8'h00, index};
    end
  end

endmodule

// File: rtl/mc6502_memory_controller.sv
// Bus-side stage of the 6502 core: fetches, effective-address generation,
// data reads/stores and RMW writeback over one synchronous-read memory port.
module mc6502_memory_controller
  import mc6502_memory_controller_pkg::*;
#(
  parameter bit ZP_WRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_x,
  input  logic        id2mc_fetch,
  input  logic        id2mc_start,
  input  logic        id2mc_write,
  input  logic [2:0]  id2mc_mode,
  input  logic [7:0]  id2mc_lo,
  input  logic [7:0]  id2mc_hi,
  input  logic [7:0]  id2mc_wdata,
  output logic [7:0]  mc2id_data,
  output logic        mc2id_done,
  output logic        mc2id_busy,
  input  logic [7:0]  ec2mc_data,
  input  logic        ec2mc_store,
  input  logic [7:0]  rf2mc_pcl,
  input  logic [7:0]  rf2mc_pch,
  input  logic [7:0]  rf2mc_x,
  input  logic [7:0]  rf2mc_y,
  output logic [15:0] mem_adr,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  output logic        mem_rd,
  output logic        mem_we
);

  mc_state_e   state_q, state_d;
  req_e        kind_q, kind_d;
  logic [15:0] ea_q, ea_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  idx_q, idx_d;

  am_e         mode;
  logic [15:0] ea_base, ea_sum, ptr_inc;
  logic [7:0]  ea_index;
  logic        ea_wrap;

  assign mode = am_e'(id2mc_mode);

  // One adder serves direct modes in IDLE and the INDY post-index in
  // PTR_WAIT, where the pointer high byte is still on mem_din.
  always_comb begin
    ea_base  = {8'h00, id2mc_lo};
    ea_index = '0;
    ea_wrap  = 1'b0;
    if (state_q == MC_PTR_WAIT) begin
      ea_base  = {mem_din, lo_q};
      ea_index = idx_q;
    end else begin
      unique case (mode)
        AM_ZPX:  begin ea_index = rf2mc_x; ea_wrap = ZP_WRAP; end
        AM_ZPY:  begin ea_index = rf2mc_y; ea_wrap = ZP_WRAP; end
        AM_ABS:  ea_base = {id2mc_hi, id2mc_lo};
        AM_ABSX: begin ea_base = {id2mc_hi, id2mc_lo}; ea_index = rf2mc_x; end
        AM_ABSY: begin ea_base = {id2mc_hi, id2mc_lo}; ea_index = rf2mc_y; end
        default: ;
      endcase
    end
  end

  mc6502_address_adder u_ea_adder (
    .base    (ea_base),
    .index   (ea_index),
    .zp_wrap (ea_wrap),
    .sum     (ea_sum)
  );

  mc6502_address_adder u_ptr_adder (
    .base    ({8'h00, ptr_q}),
    .index   (8'd1),
    .zp_wrap (ZP_WRAP),
    .sum     (ptr_inc)
  );

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    ea_d    = ea_q;
    pc_d    = pc_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    wdata_d = wdata_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    unique case (state_q)
      MC_IDLE: begin
        if (ec2mc_store) begin
          kind_d  = REQ_STORE;
          wdata_d = ec2mc_data;
          state_d = MC_ACCESS;
        end else if (id2mc_start) begin
          kind_d  = id2mc_write ? REQ_WRITE : REQ_READ;
          wdata_d = id2mc_wdata;
          // INDX is treated as INDY with a zero post-index.
          if (mode == AM_INDX) begin
            ptr_d   = id2mc_lo + rf2mc_x;
            idx_d   = '0;
            state_d = MC_PTR_LO;
          end else if (mode == AM_INDY) begin
            ptr_d   = id2mc_lo;
            idx_d   = rf2mc_y;
            state_d = MC_PTR_LO;
          end else begin
            ea_d    = ea_sum;
            state_d = MC_ACCESS;
          end
        end else if (id2mc_fetch) begin
          kind_d  = REQ_FETCH;
          pc_d    = {rf2mc_pch, rf2mc_pcl};
          state_d = MC_ACCESS;
        end
      end
      MC_PTR_LO:   state_d = MC_PTR_HI;
      MC_PTR_HI: begin
        lo_d    = mem_din;
        state_d = MC_PTR_WAIT;
      end
      MC_PTR_WAIT: begin
        hi_d    = mem_din;
        ea_d    = ea_sum;
        state_d = MC_ACCESS;
      end
      MC_ACCESS:   state_d = is_write_req(kind_q) ? MC_IDLE : MC_RD_WAIT;
      MC_RD_WAIT:  state_d = MC_IDLE;
      default:     state_d = MC_IDLE;
    endcase
  end

  always_comb begin
    mem_adr    = '0;
    mem_dout   = '0;
    mem_rd     = 1'b0;
    mem_we     = 1'b0;
    mc2id_done = 1'b0;
    mc2id_data = '0;
    mc2id_busy = (state_q != MC_IDLE);
    unique case (state_q)
      MC_PTR_LO: begin
        mem_adr = {8'h00, ptr_q};
        mem_rd  = 1'b1;
      end
      MC_PTR_HI: begin
        mem_adr = ptr_inc;
        mem_rd  = 1'b1;
      end
      MC_ACCESS: begin
        mem_adr = (kind_q == REQ_FETCH) ? pc_q : ea_q;
        if (is_write_req(kind_q)) begin
          mem_we     = 1'b1;
          mem_dout   = wdata_q;
          mc2id_done = 1'b1;
        end else begin
          mem_rd = 1'b1;
        end
      end
      MC_RD_WAIT: begin
        mc2id_done = 1'b1;
        mc2id_data = mem_din;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q <= MC_IDLE;
      kind_q  <= REQ_FETCH;
      ea_q    <= '0;
      pc_q    <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      wdata_q <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      ea_q    <= ea_d;
      pc_q    <= pc_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      wdata_q <= wdata_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_mc6502_memory_controller.sv
// Bench for mc6502_memory_controller: two instances (ZP_WRAP=1 and 0), each
// with its own synchronous-read memory, checked against fixed vectors and a model.
module tb_mc6502_memory_controller;

  logic        clk = 1'b0;
  logic        rst_x;
  logic        id2mc_fetch, id2mc_start, id2mc_write, ec2mc_store;
  logic [2:0]  id2mc_mode;
  logic [7:0]  id2mc_lo, id2mc_hi, id2mc_wdata, ec2mc_data;
  logic [7:0]  rf2mc_pcl, rf2mc_pch, rf2mc_x, rf2mc_y;
  logic        load_mem;

  logic [15:0] adr_o  [2];
  logic [7:0]  dout_o [2];
  logic [7:0]  din_i  [2];
  logic [7:0]  data_o [2];
  logic        rd_o   [2];
  logic        we_o   [2];
  logic        done_o [2];
  logic        busy_o [2];

  logic [7:0]  mem  [2][65536];
  logic [7:0]  refm [2][65536];
  logic [15:0] tr   [2][11];
  int          last_ea [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mc6502_memory_controller #(.ZP_WRAP(1'b1)) dut0 (
    .clk(clk), .rst_x(rst_x),
    .id2mc_fetch(id2mc_fetch), .id2mc_start(id2mc_start), .id2mc_write(id2mc_write),
    .id2mc_mode(id2mc_mode), .id2mc_lo(id2mc_lo), .id2mc_hi(id2mc_hi), .id2mc_wdata(id2mc_wdata),
    .mc2id_data(data_o[0]), .mc2id_done(done_o[0]), .mc2id_busy(busy_o[0]),
    .ec2mc_data(ec2mc_data), .ec2mc_store(ec2mc_store),
    .rf2mc_pcl(rf2mc_pcl), .rf2mc_pch(rf2mc_pch), .rf2mc_x(rf2mc_x), .rf2mc_y(rf2mc_y),
    .mem_adr(adr_o[0]), .mem_dout(dout_o[0]), .mem_din(din_i[0]), .mem_rd(rd_o[0]), .mem_we(we_o[0])
  );

  mc6502_memory_controller #(.ZP_WRAP(1'b0)) dut1 (
    .clk(clk), .rst_x(rst_x),
    .id2mc_fetch(id2mc_fetch), .id2mc_start(id2mc_start), .id2mc_write(id2mc_write),
    .id2mc_mode(id2mc_mode), .id2mc_lo(id2mc_lo), .id2mc_hi(id2mc_hi), .id2mc_wdata(id2mc_wdata),
    .mc2id_data(data_o[1]), .mc2id_done(done_o[1]), .mc2id_busy(busy_o[1]),
    .ec2mc_data(ec2mc_data), .ec2mc_store(ec2mc_store),
    .rf2mc_pcl(rf2mc_pcl), .rf2mc_pch(rf2mc_pch), .rf2mc_x(rf2mc_x), .rf2mc_y(rf2mc_y),
    .mem_adr(adr_o[1]), .mem_dout(dout_o[1]), .mem_din(din_i[1]), .mem_rd(rd_o[1]), .mem_we(we_o[1])
  );

  function automatic logic [7:0] init_byte(int a);
    case (a)
      16'h1234: return 8'hA9;
      16'h0010: return 8'h55;
      16'h0110: return 8'h66;
      16'h00FF: return 8'hF0;
      16'h0000: return 8'h12;
      16'h0100: return 8'h34;
      16'h1310: return 8'h9A;
      16'h3510: return 8'hBC;
      default:  return 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
    endcase
  endfunction

  always @(posedge clk) begin
    if (load_mem) begin
      for (int a = 0; a < 65536; a++) begin
        mem[0][a] <= init_byte(a);
        mem[1][a] <= init_byte(a);
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (rd_o[d]) din_i[d] <= mem[d][adr_o[d]];
        if (we_o[d]) mem[d][adr_o[d]] <= dout_o[d];
      end
    end
  end

  typedef struct {
    bit          fetch, start, store, wr, late;
    logic [2:0]  mode;
    logic [7:0]  lo, hi, x, y, wd, sd;
    logic [15:0] pc;
    bit          exp_we;
    int          lat;
    logic [15:0] adr0, adr1;
    logic [7:0]  dat0, dat1, dout;
  } vec_t;

  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[dut%0d]: got %0h expected %0h", nm, d, act, exp);
  endtask

  task automatic clear_req();
    id2mc_fetch = 1'b0; id2mc_start = 1'b0; ec2mc_store = 1'b0; id2mc_write = 1'b0;
  endtask

  // Issue one request and observe both instances for a fixed 10-cycle window.
  task automatic apply(input vec_t v);
    int nd[2], dk[2], nb[2];
    logic [15:0] a_adr[2];
    logic [7:0]  a_dout[2], dat[2];
    logic        a_rd[2], a_we[2];
    int acc_k;
    acc_k = v.exp_we ? v.lat : v.lat - 1;
    for (int d = 0; d < 2; d++) begin
      nd[d] = 0; dk[d] = 0; nb[d] = 0; dat[d] = '0;
      a_adr[d] = '0; a_dout[d] = '0; a_rd[d] = 1'b0; a_we[d] = 1'b0;
    end
    @(negedge clk);
    id2mc_fetch = v.fetch; id2mc_start = v.start; ec2mc_store = v.store; id2mc_write = v.wr;
    id2mc_mode = v.mode; id2mc_lo = v.lo; id2mc_hi = v.hi; id2mc_wdata = v.wd;
    rf2mc_x = v.x; rf2mc_y = v.y; ec2mc_data = v.sd;
    rf2mc_pch = v.pc[15:8]; rf2mc_pcl = v.pc[7:0];
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        tr[d][k] = adr_o[d];
        if (busy_o[d]) nb[d]++;
        if (done_o[d]) begin nd[d]++; dk[d] = k; dat[d] = data_o[d]; end
        if (k == acc_k) begin
          a_adr[d] = adr_o[d]; a_rd[d] = rd_o[d]; a_we[d] = we_o[d]; a_dout[d] = dout_o[d];
        end
      end
      if (k == 1) clear_req();
      if (v.late && k == 2) id2mc_fetch = 1'b1;
      if (k == 3) id2mc_fetch = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      chk("done_count", d, nd[d], 1);
      chk("done_cycle", d, dk[d], v.lat);
      chk("busy_cycles", d, nb[d], v.lat);
      chk("access_adr", d, a_adr[d], (d == 0) ? v.adr0 : v.adr1);
      chk("access_rd", d, a_rd[d], !v.exp_we);
      chk("access_we", d, a_we[d], v.exp_we);
      chk("access_dout", d, a_dout[d], v.exp_we ? v.dout : 8'h00);
      if (!v.exp_we) chk("read_data", d, dat[d], (d == 0) ? v.dat0 : v.dat1);
    end
  endtask

  task automatic check_idle_outputs(string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_adr"}, d, adr_o[d], 0);
      chk({tag, "_dout"}, d, dout_o[d], 0);
      chk({tag, "_rd"}, d, rd_o[d], 0);
      chk({tag, "_we"}, d, we_o[d], 0);
      chk({tag, "_done"}, d, done_o[d], 0);
      chk({tag, "_busy"}, d, busy_o[d], 0);
      chk({tag, "_data"}, d, data_o[d], 0);
    end
  endtask

  function automatic int model_ea(int d, int mode, int lo, int hi, int x, int y);
    bit w = (d == 0);
    int p, p1, base;
    case (mode)
      0: return lo;
      1: return w ? (lo + x) % 256 : lo + x;
      2: return w ? (lo + y) % 256 : lo + y;
      3: return hi * 256 + lo;
      4: return (hi * 256 + lo + x) % 65536;
      5: return (hi * 256 + lo + y) % 65536;
      default: begin
        p    = (mode == 6) ? (lo + x) % 256 : lo;
        p1   = w ? (p + 1) % 256 : p + 1;
        base = int'(refm[d][p1]) * 256 + int'(refm[d][p]);
        return (mode == 7) ? (base + y) % 65536 : base;
      end
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_x = 1'b0; load_mem = 1'b1; clear_req();
    @(posedge clk);
    #1 load_mem = 1'b0;
    @(negedge clk);
  endtask

  vec_t tbl [13];
  vec_t v;
  int   nd_after[2];
  int   ea[2];

  initial begin
    tbl[0]  = '{0,0,1,0,0, 3'd0, 8'h00,8'h00,8'h00,8'h00,8'h00,8'h12, 16'h0000, 1,1, 16'h0000,16'h0000, 8'h00,8'h00,8'h12};
    tbl[1]  = '{1,0,0,0,0, 3'd0, 8'h00,8'h00,8'h00,8'h00,8'h00,8'h00, 16'h1234, 0,2, 16'h1234,16'h1234, 8'hA9,8'hA9,8'h00};
    tbl[2]  = '{0,1,0,0,0, 3'd1, 8'hF0,8'h00,8'h20,8'h00,8'h00,8'h00, 16'h0000, 0,2, 16'h0010,16'h0110, 8'h55,8'h66,8'h00};
    tbl[3]  = '{0,1,0,0,0, 3'd7, 8'hFF,8'h00,8'h00,8'h20,8'h00,8'h00, 16'h0000, 0,5, 16'h1310,16'h3510, 8'h9A,8'hBC,8'h00};
    tbl[4]  = '{0,1,0,1,0, 3'd4, 8'hFF,8'h20,8'h01,8'h00,8'h77,8'h00, 16'h0000, 1,1, 16'h2100,16'h2100, 8'h00,8'h00,8'h77};
    tbl[5]  = '{0,0,1,0,0, 3'd0, 8'h00,8'h00,8'h00,8'h00,8'h00,8'h78, 16'h0000, 1,1, 16'h2100,16'h2100, 8'h00,8'h00,8'h78};
    tbl[6]  = '{1,1,1,0,0, 3'd0, 8'h05,8'h00,8'h00,8'h00,8'h00,8'h79, 16'h1234, 1,1, 16'h2100,16'h2100, 8'h00,8'h00,8'h79};
    tbl[7]  = '{0,1,0,0,0, 3'd4, 8'hFF,8'hFF,8'h01,8'h00,8'h00,8'h00, 16'h0000, 0,2, 16'h0000,16'h0000, 8'h12,8'h12,8'h00};
    tbl[8]  = '{0,1,0,0,1, 3'd6, 8'hFE,8'h00,8'h01,8'h00,8'h00,8'h00, 16'h0000, 0,5, 16'h12F0,16'h34F0, 8'hB8,8'h9E,8'h00};
    tbl[9]  = '{0,1,0,1,0, 3'd2, 8'h80,8'h00,8'h00,8'h90,8'hAB,8'h00, 16'h0000, 1,1, 16'h0010,16'h0110, 8'h00,8'h00,8'hAB};
    tbl[10] = '{0,1,0,1,0, 3'd6, 8'h10,8'h00,8'hF5,8'h00,8'hC3,8'h00, 16'h0000, 1,4, 16'h5C5F,16'h5C5F, 8'h00,8'h00,8'hC3};
    tbl[11] = '{0,1,0,0,0, 3'd5, 8'h30,8'h12,8'h00,8'h04,8'h00,8'h00, 16'h0000, 0,2, 16'h1234,16'h1234, 8'hA9,8'hA9,8'h00};
    tbl[12] = '{0,1,0,0,0, 3'd0, 8'h10,8'h00,8'h00,8'h00,8'h00,8'h00, 16'h0000, 0,2, 16'h0010,16'h0010, 8'hAB,8'h55,8'h00};

    rst_x = 1'b0; load_mem = 1'b1; clear_req();
    id2mc_mode = '0; id2mc_lo = '0; id2mc_hi = '0; id2mc_wdata = '0; ec2mc_data = '0;
    rf2mc_pcl = '0; rf2mc_pch = '0; rf2mc_x = '0; rf2mc_y = '0;
    @(posedge clk);
    #1 load_mem = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    rst_x = 1'b1;

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i]);
      if (i == 3) begin
        chk("indy_ptr_lo_adr", 0, tr[0][1], 16'h00FF);
        chk("indy_ptr_hi_adr", 0, tr[0][2], 16'h0000);
        chk("indy_ptr_hi_adr", 1, tr[1][2], 16'h0100);
      end
    end

    // Reset asserted while an INDX read sits in PTR_HI.
    @(negedge clk);
    id2mc_start = 1'b1; id2mc_mode = 3'd6; id2mc_lo = 8'h10; rf2mc_x = 8'hF5;
    @(negedge clk);
    clear_req();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) chk("pre_reset_busy", d, busy_o[d], 1);
    rst_x = 1'b0;
    #1 check_idle_outputs("mid_reset");
    @(negedge clk);
    rst_x = 1'b1;
    nd_after[0] = 0; nd_after[1] = 0;
    repeat (6) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (done_o[d]) nd_after[d]++;
    end
    for (int d = 0; d < 2; d++) chk("no_done_after_abort", d, nd_after[d], 0);
    apply(tbl[1]);

    // Randomised phase against the reference model from a fresh reset.
    do_reset();
    rst_x = 1'b1;
    for (int a = 0; a < 65536; a++) begin
      refm[0][a] = init_byte(a);
      refm[1][a] = init_byte(a);
    end
    last_ea[0] = 0; last_ea[1] = 0;
    for (int n = 0; n < 200; n++) begin
      int r;
      r = $urandom_range(0, 9);
      v = '{default: '0};
      v.lo = 8'($urandom); v.hi = 8'($urandom); v.x = 8'($urandom); v.y = 8'($urandom);
      v.wd = 8'($urandom); v.sd = 8'($urandom); v.pc = 16'($urandom);
      v.mode = 3'($urandom_range(0, 7));
      if (r < 2) begin
        v.store = 1'b1; v.exp_we = 1'b1; v.lat = 1; v.dout = v.sd;
        ea[0] = last_ea[0]; ea[1] = last_ea[1];
      end else if (r < 4) begin
        v.fetch = 1'b1; v.lat = 2;
        ea[0] = v.pc; ea[1] = v.pc;
      end else begin
        v.start = 1'b1; v.wr = ($urandom_range(0, 2) == 0); v.exp_we = v.wr; v.dout = v.wd;
        v.lat = ((v.mode >= 6) ? 4 : 1) + (v.wr ? 0 : 1);
        for (int d = 0; d < 2; d++) begin
          ea[d] = model_ea(d, v.mode, v.lo, v.hi, v.x, v.y);
          last_ea[d] = ea[d];
        end
      end
      v.adr0 = 16'(ea[0]); v.adr1 = 16'(ea[1]);
      v.dat0 = refm[0][ea[0]]; v.dat1 = refm[1][ea[1]];
      apply(v);
      if (v.exp_we) begin
        refm[0][ea[0]] = v.dout;
        refm[1][ea[1]] = v.dout;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
